packet_splitter: RTL and testbench
==================================

PACKET_SPLITTER -- requirements
Module: packet_splitter

Interface
REQ-001 SHALL have parameter InWidth, default 64, width of one packet word in bits (enqueue-stage output, block start bits included).
REQ-002 SHALL have parameter BandWidth, default 16, bits emitted per split.
REQ-003 SHALL have parameter MaxSplits, default ceil(InWidth/BandWidth), maximum splits per packet; SplitW = $clog2(MaxSplits+1).
REQ-004 SHALL have port clk_i, input, 1, single clock; all flops rising-edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_i, input, 1, packet word valid.
REQ-007 SHALL have port ready_o, output, 1, packet word accepted when valid_i && ready_o.
REQ-008 SHALL have port data_i, input, InWidth, packet word.
REQ-009 SHALL have port num_splits_i, input, SplitW, splits to send for this word (from enqueue stage send_hdr_req_num_splits).
REQ-010 SHALL have port valid_o, output, 1, split valid.
REQ-011 SHALL have port ready_i, input, 1, split accepted when valid_o && ready_i.
REQ-012 SHALL have port data_o, output, BandWidth, current split payload.
REQ-013 SHALL have ports first_o and last_o, output, 1 each, current split is first / last of packet.
REQ-014 SHALL have port split_idx_o, output, SplitW, index of current split (0-based).
REQ-015 SHALL have port pkt_cnt_o, output, 16, completed-packet counter (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE and SEND.
REQ-017 IDLE: valid_o=0; ready_o=1; on valid_i capture data_i into word register, latch eff_splits, clear idx, go SEND.
REQ-018 eff_splits SHALL be 1 when num_splits_i==0, MaxSplits when num_splits_i>MaxSplits, else num_splits_i.
REQ-019 SEND: valid_o=1; data_o = word bits [idx*BandWidth +: BandWidth], bits at or above InWidth driven 0.
REQ-020 first_o = (idx==0); last_o = (idx==eff_splits-1); split_idx_o = idx; all only meaningful while valid_o=1, driven 0 in IDLE.
REQ-021 SEND with ready_i && !last_o: idx increments by 1; data_o, valid_o otherwise held stable.
REQ-022 SEND with ready_i && last_o: ready_o=1 combinationally this cycle; if valid_i, capture new word and restart at idx 0 in SEND (back-to-back, no bubble); else go IDLE.
REQ-023 SEND without last-split handshake: ready_o=0.
REQ-024 Latency: a word accepted in cycle N SHALL present split 0 on data_o in cycle N+1.
REQ-025 valid_o SHALL never drop while in SEND until the last split handshakes (AXI-stream-style stability).
REQ-026 Throughput: eff_splits cycles per packet with ready_i held high; no idle cycle between packets.

Reset
REQ-027 rst_ni low SHALL asynchronously force state IDLE, idx 0, eff_splits 0, word register 0, pkt_cnt_o 0.
REQ-028 Reset mid-packet SHALL discard remaining splits; valid_o=0 and ready_o=1 from the first cycle after release.

Configuration
REQ-029 Macro SERIAL_LINK_SPLITTER_PKT_CNT_EN defined: pkt_cnt_o increments by 1 on every last-split handshake, wraps 0xFFFF->0x0000.
REQ-030 Macro undefined: pkt_cnt_o tied to 0, no counter flops.

Verification
REQ-031 InWidth=64, BandWidth=16, word 0x4444_3333_2222_1111, num_splits_i=4, ready_i=1 -> data_o 0x1111,0x2222,0x3333,0x4444 cycles N+1..N+4; first_o on split 0, last_o on split 3.
REQ-032 num_splits_i=0 -> one split 0x1111 with first_o=last_o=1; num_splits_i=7 -> four splits (clamped).
REQ-033 InWidth=40, BandWidth=16, word 0xAB_CDEF_1234, num_splits_i=3 -> 0x1234, 0xCDEF, 0x00AB (upper bits zero-padded).
REQ-034 ready_i toggled 1,0,0,1,... during packet -> data_o/split_idx_o held while ready_i=0; ready_o=0 until last handshake.
REQ-035 Two packets presented back-to-back with ready_i=1 -> second packet split 0 appears cycle after first packet's last split; pkt_cnt_o=2 with macro, 0 without.
REQ-036 rst_ni asserted after split 1 of 4 -> valid_o=0, pkt_cnt_o=0 immediately; next packet starts at split_idx_o=0.

Source files
------------

// File: rtl/packet_splitter.sv
// Splits one wide packet word into BandWidth-bit slices on a valid/ready stream.
// Optional completed-packet counter enabled by SERIAL_LINK_SPLITTER_PKT_CNT_EN.
module packet_splitter #(
    parameter int InWidth   = 64,
    parameter int BandWidth = 16,
    parameter int MaxSplits = (InWidth + BandWidth - 1) / BandWidth,
    parameter int SplitW    = $clog2(MaxSplits + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [InWidth-1:0]   data_i,
    input  logic [SplitW-1:0]    num_splits_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [BandWidth-1:0] data_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic [SplitW-1:0]    split_idx_o,
    output logic [15:0]          pkt_cnt_o
);

    // Both streams transfer on a cycle where valid and ready are both high;
    // valid_o never drops in SEND until the last split has been accepted.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Padded word width so that every split index up to MaxSplits selects real bits.
    localparam int PadW = (MaxSplits * BandWidth > InWidth) ? MaxSplits * BandWidth : InWidth;

    logic [0:0]         state_q, state_d;
    logic [InWidth-1:0] word_q, word_d;
    logic [SplitW-1:0]  splits_q, splits_d;
    logic [SplitW-1:0]  idx_q, idx_d;
    logic [SplitW-1:0]  eff_splits;
    logic [PadW-1:0]    word_pad;
    logic               sending;
    logic               is_last;
    logic               last_hs;
    logic               accept;

    assign sending  = (state_q == ST_SEND);
    assign is_last  = (idx_q == splits_q - SplitW'(1));
    assign last_hs  = sending && ready_i && is_last;
    assign word_pad = PadW'(word_q);

    // A zero request still sends one split; oversize requests clamp to MaxSplits.
    always_comb begin
        eff_splits = num_splits_i;
        if (num_splits_i == '0) begin
            eff_splits = SplitW'(1);
        end else if (num_splits_i > SplitW'(MaxSplits)) begin
            eff_splits = SplitW'(MaxSplits);
        end
    end

    assign ready_o     = !sending || last_hs;
    assign accept      = valid_i && ready_o;
    assign valid_o     = sending;
    assign first_o     = sending && (idx_q == '0);
    assign last_o      = sending && is_last;
    assign split_idx_o = sending ? idx_q : '0;

    always_comb begin
        data_o = '0;
        if (sending) begin
            data_o = word_pad[int'(idx_q) * BandWidth +: BandWidth];
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        splits_d = splits_q;
        idx_d    = idx_q;
        if (accept) begin
            state_d  = ST_SEND;
            word_d   = data_i;
            splits_d = eff_splits;
            idx_d    = '0;
        end else if (last_hs) begin
            state_d = ST_IDLE;
        end else if (sending && ready_i) begin
            idx_d = idx_q + SplitW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            splits_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            splits_q <= splits_d;
            idx_q    <= idx_d;
        end
    end

`ifdef SERIAL_LINK_SPLITTER_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q <= '0;
        end else if (last_hs) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`else
    assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_packet_splitter.sv
// Self-checking bench for packet_splitter: queue-based stream model, vector table,
// hand-written corner sequences and a narrow 40-bit instance.
module tb_packet_splitter;

    logic        clk;
    logic        rst_ni;

    logic        valid_i, ready_o, valid_o, ready_i, first_o, last_o;
    logic [63:0] data_i;
    logic [2:0]  num_splits_i, split_idx_o;
    logic [15:0] data_o, pkt_cnt_o;

    logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_first_o, b_last_o;
    logic [39:0] b_data_i;
    logic [1:0]  b_num_splits_i, b_split_idx_o;
    logic [15:0] b_data_o, b_pkt_cnt_o;

    packet_splitter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .num_splits_i(num_splits_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .first_o(first_o),
        .last_o(last_o), .split_idx_o(split_idx_o), .pkt_cnt_o(pkt_cnt_o)
    );

    packet_splitter #(.InWidth(40), .BandWidth(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i), .num_splits_i(b_num_splits_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .first_o(b_first_o),
        .last_o(b_last_o), .split_idx_o(b_split_idx_o), .pkt_cnt_o(b_pkt_cnt_o)
    );

    // ---------------- clock / counters ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] d;
        logic        f;
        logic        l;
        int          idx;
    } split_t;

    split_t      exp_q[$];
    split_t      obs_q[$];
    logic [15:0] exp_cnt = 16'd0;

    function automatic int eff_of(input int n);
        if (n == 0) return 1;
        if (n > 4) return 4;
        return n;
    endfunction

    // Sampled on the falling edge; model advances as the coming rising edge will.
    always @(negedge clk) begin
        logic exp_valid, exp_ready;
        split_t s;
        if (!rst_ni) begin
            exp_q.delete();
            exp_cnt = 16'd0;
            chk("rst_valid_o", valid_o, 0);
            chk("rst_ready_o", ready_o, 1);
            chk("rst_pkt_cnt", pkt_cnt_o, 0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = !exp_valid || (exp_q[0].l && ready_i);
            chk("valid_o", valid_o, exp_valid);
            chk("ready_o", ready_o, exp_ready);
            if (exp_valid) begin
                chk("data_o", data_o, exp_q[0].d);
                chk("first_o", first_o, exp_q[0].f);
                chk("last_o", last_o, exp_q[0].l);
                chk("split_idx_o", split_idx_o, exp_q[0].idx);
            end else begin
                chk("idle_data_o", data_o, 0);
                chk("idle_flags", {first_o, last_o, split_idx_o}, 0);
            end
`ifdef SERIAL_LINK_SPLITTER_PKT_CNT_EN
            chk("pkt_cnt_o", pkt_cnt_o, exp_cnt);
`else
            chk("pkt_cnt_o", pkt_cnt_o, 0);
`endif
            if (exp_valid && ready_i) begin
                s.d = data_o; s.f = first_o; s.l = last_o; s.idx = int'(split_idx_o);
                obs_q.push_back(s);
                if (exp_q[0].l) exp_cnt = exp_cnt + 16'd1;
                void'(exp_q.pop_front());
            end
            if (valid_i && exp_ready) begin
                int n;
                n = eff_of(int'(num_splits_i));
                for (int k = 0; k < n; k++) begin
                    s.d   = 16'((data_i >> (16 * k)) & 64'hFFFF);
                    s.f   = (k == 0);
                    s.l   = (k == n - 1);
                    s.idx = k;
                    exp_q.push_back(s);
                end
                n_acc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; valid_i = 1'b0; b_valid_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] w, input logic [2:0] n);
        int start;
        int c;
        start = n_acc;
        valid_i = 1'b1; data_i = w; num_splits_i = n;
        c = 0;
        while (n_acc == start && c < 50) begin
            step();
            c++;
        end
        if (n_acc == start) chk("accept_timeout", 1, 0);
        valid_i = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 50) begin
            step();
            c++;
        end
        if (obs_q.size() < n) chk("split_timeout", obs_q.size(), n);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0]      word;
        logic [2:0]       nsp;
        int               n;
        logic [3:0][15:0] d;
    } vec_t;

    vec_t vecs[6];
    logic [15:0] b_exp[3];
    int ready_pat[10];

    initial begin
        vecs[0] = '{64'h4444_3333_2222_1111, 3'd4, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vecs[1] = '{64'h4444_3333_2222_1111, 3'd0, 1, {16'h0, 16'h0, 16'h0, 16'h1111}};
        vecs[2] = '{64'h4444_3333_2222_1111, 3'd7, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, 3'd2, 2, {16'h0, 16'h0, 16'hCAFE, 16'hF00D}};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 3'd3, 3, {16'h0, 16'h4567, 16'h89AB, 16'hCDEF}};
        vecs[5] = '{64'hFFFF_0000_0000_0000, 3'd5, 4, {16'hFFFF, 16'h0, 16'h0, 16'h0}};
        b_exp     = '{16'h1234, 16'hCDEF, 16'h00AB};
        ready_pat = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};

        valid_i = 1'b0; ready_i = 1'b0; data_i = '0; num_splits_i = '0;
        b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0; b_num_splits_i = '0;
        rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();

        // table: full-rate packets, observed split stream compared to constants
        ready_i = 1'b1;
        foreach (vecs[i]) begin
            obs_q.delete();
            send_word(vecs[i].word, vecs[i].nsp);
            wait_obs(vecs[i].n);
            chk("tbl_count", obs_q.size(), vecs[i].n);
            for (int k = 0; k < vecs[i].n && k < obs_q.size(); k++) begin
                chk("tbl_data", obs_q[k].d, vecs[i].d[k]);
                chk("tbl_first", obs_q[k].f, k == 0);
                chk("tbl_last", obs_q[k].l, k == vecs[i].n - 1);
            end
            step();
        end

        // backpressure: outputs held while ready_i is low
        obs_q.delete();
        send_word(64'h4444_3333_2222_1111, 3'd4);
        foreach (ready_pat[i]) begin
            ready_i = ready_pat[i][0];
            step();
        end
        ready_i = 1'b1;
        wait_obs(4);
        chk("bp_count", obs_q.size(), 4);
        if (obs_q.size() == 4) chk("bp_last_data", obs_q[3].d, 16'h4444);
        step();

        // back-to-back packets, no bubble, counter reaches 2
        do_reset();
        obs_q.delete();
        ready_i = 1'b1;
        send_word(64'hAAAA_BBBB_CCCC_DDDD, 3'd4);
        send_word(64'h0000_0000_5555_6666, 3'd2);
        wait_obs(6);
        chk("b2b_count", obs_q.size(), 6);
        if (obs_q.size() == 6) begin
            chk("b2b_second_first", obs_q[4].f, 1);
            chk("b2b_second_data", obs_q[4].d, 16'h6666);
        end
        step();
`ifdef SERIAL_LINK_SPLITTER_PKT_CNT_EN
        chk("b2b_pkt_cnt", pkt_cnt_o, 2);
`else
        chk("b2b_pkt_cnt", pkt_cnt_o, 0);
`endif

        // reset after split 1 of 4
        obs_q.delete();
        send_word(64'h4444_3333_2222_1111, 3'd4);
        wait_obs(2);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_pkt_cnt", pkt_cnt_o, 0);
        step();
        rst_ni = 1'b1;
        obs_q.delete();
        send_word(64'h0000_0000_9999_8888, 3'd2);
        wait_obs(2);
        if (obs_q.size() >= 1) begin
            chk("midrst_restart_idx", obs_q[0].idx, 0);
            chk("midrst_restart_data", obs_q[0].d, 16'h8888);
        end
        step();

        // narrow instance: 40-bit word, top split zero-padded
        b_valid_i = 1'b1; b_data_i = 40'hAB_CDEF_1234; b_num_splits_i = 2'd3; b_ready_i = 1'b1;
        @(negedge clk);
        chk("b_idle_ready_o", b_ready_o, 1);
        chk("b_idle_valid_o", b_valid_o, 0);
        step();
        b_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_valid_o", b_valid_o, 1);
            chk("b_data_o", b_data_o, b_exp[k]);
            chk("b_first_o", b_first_o, k == 0);
            chk("b_last_o", b_last_o, k == 2);
            chk("b_split_idx_o", b_split_idx_o, k);
        end
        @(negedge clk);
        chk("b_end_valid_o", b_valid_o, 0);
        step();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            ready_i      = ($urandom_range(0, 3) != 0);
            valid_i      = ($urandom_range(0, 2) != 0);
            data_i       = {$urandom, $urandom};
            num_splits_i = 3'($urandom_range(0, 7));
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) step();

`ifdef SERIAL_LINK_SPLITTER_PKT_CNT_EN
        chk("b_pkt_cnt", b_pkt_cnt_o, 1);
`else
        chk("b_pkt_cnt", b_pkt_cnt_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
